fu_broadcast_arbiter: RTL

Collects completed results from NUM_FU functional units of the FU_* family. Each unit issues a one-cycle done pulse and holds its result and tag until it receives queued. This block arbitrates the units round-robin into a broadcast queue, one entry per cycle, and returns a one-cycle queued pulse to the granted unit so it can go idle. It drains the queue onto the common data bus (CDB) with a valid/ready handshake.

---
 rtl/fu_broadcast_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/fu_broadcast_arbiter.sv
// fu_broadcast_arbiter: round-robin collection of functional-unit results into a CDB broadcast queue
module fu_broadcast_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 7,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FU-1:0]            fu_done,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  output logic [NUM_FU-1:0]            fu_queued,
  output logic                         cdb_valid,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic                         cdb_ready
);
  localparam int PW = $clog2(NUM_FU);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  logic [NUM_FU-1:0]     pending;
  logic [NUM_FU-1:0]     req;
  logic [NUM_FU-1:0]     gnt_oh;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [TAG_WIDTH-1:0]  gnt_tag;
  logic                  gnt;
  logic                  pop;
  logic                  space;
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag  [QUEUE_DEPTH];
  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic [CW-1:0]         count;
  int                    d;
  int                    best;
  assign req       = pending | fu_done;
  assign cdb_valid = count != '0;
  assign pop       = cdb_valid & cdb_ready;
  assign space     = ~count[AW] | pop;
  assign gnt       = space & (req != '0);
  assign gnt_oh    = gnt ? {{(NUM_FU-1){1'b0}}, 1'b1} << gnt_idx : '0;
  assign cdb_data  = cdb_valid ? q_data[head] : '0;
  assign cdb_tag   = cdb_valid ? q_tag[head] : '0;
  // pick the requester closest to rr_ptr going upward with wrap
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    gnt_tag  = '0;
    best     = NUM_FU;
    d        = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      d = i - int'(rr_ptr);
      d = d < 0 ? d + NUM_FU : d;
      if (req[i] && d < best) begin
        best     = d;
        gnt_idx  = PW'(i);
        gnt_data = fu_result[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_tag  = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end
  // control state: pending requests, pointers, occupancy and the queued pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      rr_ptr    <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fu_queued <= '0;
    end else begin
      pending   <= req & ~gnt_oh;
      fu_queued <= gnt_oh;
      rr_ptr    <= !gnt ? rr_ptr : gnt_idx == PW'(NUM_FU-1) ? '0 : gnt_idx + PW'(1);
      tail      <= tail + AW'(gnt);
      head      <= head + AW'(pop);
      count     <= count + CW'(gnt) - CW'(pop);
    end
  end
  // queue storage captures the granted unit's result in the grant cycle
  always_ff @(posedge clk) begin
    if (gnt) begin
      q_data[tail] <= gnt_data;
      q_tag[tail]  <= gnt_tag;
    end
  end
endmodule
